captura_vga: RTL
================

// Module: captura_vga
// PURPOSE
// - VGA capture endpoint: samples the 640x480@60 stream (hsync, vsync, n_blank, RGB) from the VGA timing path.
// - Writes a rectangular window of one frame into pixel RAM through a simple write port.
// - Lets frame-buffer contents be read back and compared on board or in simulation.
// PARAMETERS
// - X0      default 0    first captured active column (0..639)
// - Y0      default 0    first captured active line (0..479)
// - W       default 256  window width in pixels; X0+W <= 640
// - H       default 256  window height in lines; Y0+H <= 480; W*H <= 2**AW
// - AW      default 18   write-address width
// - H_TOTAL default 800  clocks per line (used only with CAPTURA_CHECK_EN)
// - V_TOTAL default 525  lines per frame (used only with CAPTURA_CHECK_EN)
// PORTS
// - clock_25      in   1   25 MHz pixel clock; all logic on its rising edge
// - reset         in   1   synchronous, active-high
// - start         in   1   arm a single-frame capture; level-sampled
// - hsync         in   1   horizontal sync, active-low
// - vsync         in   1   vertical sync, active-low
// - n_blank       in   1   1 = active video pixel
// - red/green/blue in  8   pixel colour, each channel
// - wr_en         out  1   RAM write strobe, 1 clock per pixel
// - wr_addr       out  AW  RAM write address
// - wr_data       out  8   RGB332 = {red[7:5],green[7:5],blue[7:6]}
// - busy          out  1   1 in WAIT_VS or CAPTURE
// - done          out  1   1 in DONE
// - error_timing  out  1   sticky timing fault (CAPTURA_CHECK_EN only)
// BEHAVIOUR
// - Input stage: all pins registered once (stage S1). Edges are detected between S1 and the previous S1 value.
// - Counters:
//   - x clears to 0 while n_blank=0 and increments per active pixel.
//   - y increments on each n_blank falling edge and clears on a vsync falling edge.
// - FSM states:
//   - IDLE --start=1--> WAIT_VS.
//   - WAIT_VS --vsync falling edge--> CAPTURE.
//   - CAPTURE --write of address W*H-1--> DONE.
//   - DONE --start=1--> WAIT_VS. A held start therefore re-arms on the next frame.
// - Writes:
//   - In CAPTURE, a pixel with n_blank=1, X0<=x<X0+W and Y0<=y<Y0+H produces one write.
//   - wr_en/wr_addr/wr_data are registered; latency is 2 clocks from pin to wr_en.
// - Address: linear counter, 0 on entry to CAPTURE, +1 after each write; never wraps. Row-major, no gaps.
// - start in CAPTURE or WAIT_VS is ignored. A vsync edge in CAPTURE does not restart the frame.
// - A vsync falling edge in the same cycle as start (IDLE) is not used; capture waits for the next frame.
// - Reset values:
//   - FSM=IDLE, counters=0.
//   - wr_en=0, wr_addr=0, wr_data=0, busy=0, done=0, error_timing=0.
// - Reset mid-capture: state returns to IDLE, no further writes; RAM contents undefined.
// CONFIGURATION
// - CAPTURA_CHECK_EN defined:
//   - Counts clocks between hsync falling edges. Any period != H_TOTAL after the first edge sets error_timing.
//   - Counts hsync falling edges between vsync falling edges. Any count != V_TOTAL sets error_timing.
//   - error_timing is sticky until reset; the check is active in every state.
// - CAPTURA_CHECK_EN undefined: no check counters; error_timing tied to 0.
// TESTING
// - W=4,H=2,X0=2,Y0=1, standard 800x525 stream, ramp pixel data, start pulse
//   -> 8 writes, addr 0..7, data = pixels (2..5,1),(2..5,2); done=1 after 8th write.
// - start held high across 3 frames -> each frame writes addr 0..7 again; done pulses 1 clock per frame end.
// - reset asserted after 3rd write -> wr_en=0 next clock, busy=0, done=0; no writes on the remaining pixels.
// - start asserted mid-frame -> no write until after the next vsync falling edge.
// - With CAPTURA_CHECK_EN, one line shortened to 799 clocks -> error_timing=1, held until reset.
//   Without the macro, same stimulus -> error_timing=0.
// - Default W=H=256 full-frame run -> 65536 writes, last wr_addr=65535, RGB332 packing verified per pixel.

Source files
------------

// File: rtl/captura_vga_if.sv
// Pixel-RAM write port of the VGA capture endpoint.
// master drives the write strobe, address and RGB332 data; slave is the RAM side.
interface captura_vga_if #(
  parameter int unsigned AW = 18
) ();
  logic          wr_en;
  logic [AW-1:0] wr_addr;
  logic [7:0]    wr_data;

  modport master (output wr_en, wr_addr, wr_data);
  modport slave  (input  wr_en, wr_addr, wr_data);
endinterface

// File: rtl/captura_vga.sv
// VGA capture endpoint: samples a 640x480 VGA stream and writes a W x H window
// of one frame, packed as RGB332, into pixel RAM through a linear write port.
// Optional macro CAPTURA_CHECK_EN adds a sticky hsync-period / line-count check
// on error_timing; without it error_timing is held at 0.
module captura_vga #(
  parameter int unsigned X0      = 0,
  parameter int unsigned Y0      = 0,
  parameter int unsigned W       = 256,
  parameter int unsigned H       = 256,
  parameter int unsigned AW      = 18,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic          clock_25,
  input  logic          reset,
  input  logic          start,
  input  logic          hsync,
  input  logic          vsync,
  input  logic          n_blank,
  input  logic [7:0]    red,
  input  logic [7:0]    green,
  input  logic [7:0]    blue,
  captura_vga_if.master wr,
  output logic          busy,
  output logic          done,
  output logic          error_timing
);

  localparam int unsigned CW = 10;
  localparam int unsigned DW = CW + 1;
  localparam logic [DW-1:0] X_LO      = DW'(X0);
  localparam logic [DW-1:0] Y_LO      = DW'(Y0);
  localparam logic [DW-1:0] WIN_W     = DW'(W);
  localparam logic [DW-1:0] WIN_H     = DW'(H);
  localparam logic [AW-1:0] ADDR_LAST = AW'(W * H - 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, CAPTURE, DONE} state_t;

  state_t        state, state_n;
  logic          start_q, hsync_q, vsync_q, n_blank_q;
  logic          hsync_p, vsync_p, n_blank_p;
  logic [7:0]    pix_q;
  logic [CW-1:0] x, y;
  logic [AW-1:0] addr_cnt;
  logic [DW-1:0] dx, dy;
  logic          hs_fall, vs_fall, nb_fall;
  logic          in_win, wr_c;

  // Stage S1: register every pin once, keep the previous S1 value for edges
  always_ff @(posedge clock_25) begin
    if (reset) begin
      start_q   <= 1'b0;
      hsync_q   <= 1'b0;
      vsync_q   <= 1'b0;
      n_blank_q <= 1'b0;
      pix_q     <= '0;
      hsync_p   <= 1'b0;
      vsync_p   <= 1'b0;
      n_blank_p <= 1'b0;
    end else begin
      start_q   <= start;
      hsync_q   <= hsync;
      vsync_q   <= vsync;
      n_blank_q <= n_blank;
      pix_q     <= {red[7:5], green[7:5], blue[7:6]};
      hsync_p   <= hsync_q;
      vsync_p   <= vsync_q;
      n_blank_p <= n_blank_q;
    end
  end

  assign hs_fall = hsync_p & ~hsync_q;
  assign vs_fall = vsync_p & ~vsync_q;
  assign nb_fall = n_blank_p & ~n_blank_q;

  // Pixel position of the S1 sample: x counts active pixels, y counts lines since vsync
  always_ff @(posedge clock_25) begin
    if (reset) begin
      x <= '0;
      y <= '0;
    end else begin
      if (!n_blank_q) x <= '0;
      else            x <= x + CW'(1);
      if (vs_fall)      y <= '0;
      else if (nb_fall) y <= y + CW'(1);
    end
  end

  // Offsets are one bit wider so positions left/above the window wrap far beyond W/H
  assign dx     = {1'b0, x} - X_LO;
  assign dy     = {1'b0, y} - Y_LO;
  assign in_win = n_blank_q && (dx < WIN_W) && (dy < WIN_H);

  // FSM state register
  always_ff @(posedge clock_25) begin
    if (reset) state <= IDLE;
    else       state <= state_n;
  end

  // FSM next state and write decision; a vsync edge seen while leaving IDLE/DONE is not used
  always_comb begin
    state_n = state;
    wr_c    = 1'b0;
    unique case (state)
      IDLE:    if (start_q) state_n = WAIT_VS;
      WAIT_VS: if (vs_fall) state_n = CAPTURE;
      CAPTURE: begin
        wr_c = in_win;
        if (in_win && (addr_cnt == ADDR_LAST)) state_n = DONE;
      end
      DONE:    if (start_q) state_n = WAIT_VS;
      default: state_n = IDLE;
    endcase
  end

  // Linear write address: cleared on entry to CAPTURE, saturates at the last word
  always_ff @(posedge clock_25) begin
    if (reset) begin
      addr_cnt <= '0;
    end else if ((state == WAIT_VS) && (state_n == CAPTURE)) begin
      addr_cnt <= '0;
    end else if (wr_c && (addr_cnt != ADDR_LAST)) begin
      addr_cnt <= addr_cnt + AW'(1);
    end
  end

  // Registered write port and status flags
  always_ff @(posedge clock_25) begin
    if (reset) begin
      wr.wr_en   <= 1'b0;
      wr.wr_addr <= '0;
      wr.wr_data <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
    end else begin
      wr.wr_en <= wr_c;
      if (wr_c) begin
        wr.wr_addr <= addr_cnt;
        wr.wr_data <= pix_q;
      end
      busy <= (state_n == WAIT_VS) || (state_n == CAPTURE);
      done <= (state_n == DONE);
    end
  end

`ifdef CAPTURA_CHECK_EN
  localparam int unsigned TW = 16;

  logic [TW-1:0] hs_cnt, ln_cnt, ln_total;
  logic          hs_seen, vs_seen, err_q;

  // A line edge coinciding with the frame edge still belongs to the closing frame
  assign ln_total = ln_cnt + TW'(hs_fall);

  // Sticky check of line period and lines per frame, active in every state
  always_ff @(posedge clock_25) begin
    if (reset) begin
      hs_cnt  <= '0;
      ln_cnt  <= '0;
      hs_seen <= 1'b0;
      vs_seen <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      if (hs_fall) begin
        if (hs_seen && (hs_cnt != TW'(H_TOTAL))) err_q <= 1'b1;
        hs_cnt  <= TW'(1);
        hs_seen <= 1'b1;
      end else if (hs_cnt != '1) begin
        hs_cnt <= hs_cnt + TW'(1);
      end
      if (vs_fall) begin
        if (vs_seen && (ln_total != TW'(V_TOTAL))) err_q <= 1'b1;
        ln_cnt  <= '0;
        vs_seen <= 1'b1;
      end else if (hs_fall && (ln_cnt != '1)) begin
        ln_cnt <= ln_cnt + TW'(1);
      end
    end
  end

  assign error_timing = err_q;
`else
  assign error_timing = 1'b0;
`endif

endmodule
